// File: rtl/bt656cap_dma_fifo.sv
// Capture DMA for the BT.656 input: packs 32-bit video words into 32-byte burst
// slots of an on-chip FIFO and drains complete slots to memory over FML.
module bt656cap_dma_fifo #(
  parameter int fml_depth = 27,
  parameter int buf_depth = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic [1:0]           field_filter,
  input  logic [fml_depth-6:0] fml_adr_base,
  input  logic [fml_depth-6:0] frame_bursts,
  input  logic                 overflow_clr,
  output logic                 in_frame,
  output logic                 start_of_frame,
  output logic                 frame_done,
  output logic [7:0]           overflow_count,

  input  logic                 v_stb,
  output logic                 v_ack,
  input  logic                 v_field,
  input  logic [31:0]          v_rgb565,

  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  input  logic                 fml_ack,
  output logic [63:0]          fml_do
);

  localparam int unsigned AW    = fml_depth - 5;
  localparam int unsigned SLOTS = 1 << buf_depth;
  localparam logic [buf_depth:0] FULL = (buf_depth + 1)'(SLOTS);

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_CAPTURE = 2'd1;
  localparam logic [1:0] W_DISCARD = 2'd2;

  localparam logic [2:0] R_IDLE = 3'd0;
  localparam logic [2:0] R_T1   = 3'd1;
  localparam logic [2:0] R_T2   = 3'd2;
  localparam logic [2:0] R_T3   = 3'd3;
  localparam logic [2:0] R_T4   = 3'd4;

  logic [1:0]           w_state;
  logic [2:0]           r_state;
  logic [2:0]           w_idx;
  logic [buf_depth-1:0] wr_slot;
  logic [buf_depth-1:0] rd_slot;
  logic [buf_depth:0]   used;
  logic                 prev_field;
  logic [AW-1:0]        base_l;
  logic [AW-1:0]        bursts_l;
  logic [AW-1:0]        bursts_written;
  logic [AW-1:0]        bursts_xfer;
  logic [AW-1:0]        adr_burst;
  logic [31:0]          hold;

  logic [63:0]          mem [SLOTS*4];

  logic                 acc;
  logic                 field_edge;
  logic                 sof;
  logic                 fifo_full;
  logic                 capturing;
  logic                 ovf;
  logic                 cap_word;
  logic                 mem_we;
  logic                 commit;
  logic                 free_slot;
  logic                 last_written;
  logic                 last_xfer;
  logic                 discard_done;
  logic [1:0]           rd_entry;

  assign v_ack     = ~sys_rst;
  assign fml_stb   = (r_state == R_T1);
  assign adr_burst = base_l + bursts_xfer;
  assign fml_adr   = {adr_burst, 5'd0};

  always_comb begin
    acc          = v_stb & v_ack;
    field_edge   = acc & ((field_filter[0] & prev_field & ~v_field)
                        | (field_filter[1] & ~prev_field & v_field));
    sof          = field_edge & ~in_frame & (frame_bursts != '0);
    fifo_full    = (used == FULL);
    capturing    = (w_state == W_CAPTURE) & acc;
    ovf          = capturing & (w_idx == 3'd0) & fifo_full;
    cap_word     = capturing & ~ovf;
    mem_we       = cap_word & w_idx[0];
    commit       = cap_word & (w_idx == 3'd7);
    free_slot    = (r_state == R_T4);
    last_written = ((bursts_written + AW'(1)) == bursts_l);
    last_xfer    = ((bursts_xfer + AW'(1)) == bursts_l);
    discard_done = (w_state == W_DISCARD) & (used == '0);
  end

  // Read address runs one entry ahead of the FML beat so the registered
  // RAM output lines up with the ack cycle and the three cycles after it.
  always_comb begin
    rd_entry = 2'd0;
    case (r_state)
      R_T1:    rd_entry = fml_ack ? 2'd1 : 2'd0;
      R_T2:    rd_entry = 2'd2;
      R_T3:    rd_entry = 2'd3;
      default: rd_entry = 2'd0;
    endcase
  end

  // Even words wait in hold and are written together with the odd word as one
  // 64-bit entry, so the RAM only ever sees full-width writes.
  always_ff @(posedge sys_clk) begin
    if (mem_we)
      mem[{wr_slot, w_idx[2:1]}] <= {hold, v_rgb565};
    fml_do <= mem[{rd_slot, rd_entry}];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      w_state        <= W_IDLE;
      w_idx          <= '0;
      wr_slot        <= '0;
      bursts_written <= '0;
      hold           <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (sof) begin
            hold           <= v_rgb565;
            w_idx          <= 3'd1;
            bursts_written <= '0;
            w_state        <= W_CAPTURE;
          end
        end
        W_CAPTURE: begin
          if (ovf) begin
            w_state <= W_DISCARD;
          end else if (cap_word) begin
            if (!w_idx[0])
              hold <= v_rgb565;
            w_idx <= w_idx + 3'd1;
            if (commit) begin
              wr_slot        <= wr_slot + 1'b1;
              bursts_written <= bursts_written + AW'(1);
              if (last_written)
                w_state <= W_IDLE;
            end
          end
        end
        W_DISCARD: begin
          if (discard_done)
            w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= R_IDLE;
      rd_slot     <= '0;
      bursts_xfer <= '0;
    end else begin
      if (sof)
        bursts_xfer <= '0;
      case (r_state)
        R_IDLE: if (used != '0) r_state <= R_T1;
        R_T1:   if (fml_ack) r_state <= R_T2;
        R_T2:   r_state <= R_T3;
        R_T3:   r_state <= R_T4;
        R_T4: begin
          rd_slot     <= rd_slot + 1'b1;
          bursts_xfer <= bursts_xfer + AW'(1);
          r_state     <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      used <= '0;
    end else begin
      case ({commit, free_slot})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_frame       <= 1'b0;
      start_of_frame <= 1'b0;
      frame_done     <= 1'b0;
      prev_field     <= 1'b0;
      base_l         <= '0;
      bursts_l       <= '0;
      overflow_count <= '0;
    end else begin
      start_of_frame <= sof;
      frame_done     <= free_slot & last_xfer;
      if (acc)
        prev_field <= v_field;
      if (sof) begin
        base_l   <= fml_adr_base;
        bursts_l <= frame_bursts;
        in_frame <= 1'b1;
      end else if ((free_slot & last_xfer) | discard_done) begin
        in_frame <= 1'b0;
      end
      if (overflow_clr)
        overflow_count <= ovf ? 8'd1 : 8'd0;
      else if (ovf && (overflow_count != 8'hff))
        overflow_count <= overflow_count + 8'd1;
    end
  end

endmodule
